// File: rtl/modbus_rtu_framer_pkg.sv
// Shared types, constants and CRC helper for the Modbus RTU framer.
package modbus_rtu_framer_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    RECV,
    CHECK,
    HOLD
  } framer_state_t;

  localparam logic [15:0] MB_CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] MB_CRC_POLY   = 16'hA001;
  localparam logic [7:0]  MB_BCAST_ADDR = 8'h00;

  // Reflected CRC-16 update over one byte, LSB first.
  function automatic logic [15:0] mb_crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ MB_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_rtu_framer_buf.sv
// Frame buffer: MAX_LEN x 8 simple dual-port RAM.
// Ports: clk, rst (sync, clears rd_q only), we/wa/wd write port,
// ra read address, rd_q registered read data (1-cycle latency).
module modbus_frame_buf #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd_q
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[ra];
    end
  end

endmodule

// File: rtl/modbus_rtu_framer.sv
// Modbus RTU frame receiver: t3.5 frame delimiting, t1.5 gap check,
// CRC-16 residue check, address filter, held frame buffer.
// Inputs : clk, rst, rxv/rxd byte stream, slave_addr, bcast_en, frm_ack, rd_a.
// Outputs: frm_v/frm_len/frm_bcast frame status, rd_q buffer read data,
//          busy, saturating error counters cnt_crc/cnt_gap/cnt_ovf.
module modbus_rtu_framer
  import modbus_rtu_framer_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned T15_CYCLES = 42969,
  parameter int unsigned T35_CYCLES = 100260
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rxv,
  input  logic [7:0]                   rxd,
  input  logic [7:0]                   slave_addr,
  input  logic                         bcast_en,
  output logic                         frm_v,
  output logic [$clog2(MAX_LEN+1)-1:0] frm_len,
  output logic                         frm_bcast,
  input  logic                         frm_ack,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_a,
  output logic [7:0]                   rd_q,
  output logic                         busy,
  output logic [15:0]                  cnt_crc,
  output logic [15:0]                  cnt_gap,
  output logic [15:0]                  cnt_ovf
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned GW = $clog2(T35_CYCLES + 1);
  localparam logic [GW-1:0] GAP_T15 = GW'(T15_CYCLES);
  localparam logic [GW-1:0] GAP_T35 = GW'(T35_CYCLES);

  framer_state_t state, state_n;

  logic [GW-1:0] gap, gap_inc;
  logic          silence_done;
  logic [LW-1:0] len;
  logic [15:0]   crc;
  logic [7:0]    addr0;
  logic          ovf, gap_bad, hold_rx;

  logic          start, append, ovf_set, gap_set, accept;
  logic          inc_crc, inc_gap, inc_ovf, addr_ok;
  logic          wr_en;
  logic [AW-1:0] wr_a;

  assign gap_inc      = (gap == GAP_T35) ? gap : gap + GW'(1);
  assign silence_done = !rxv && (gap_inc == GAP_T35);
  assign addr_ok      = (addr0 == slave_addr) || (addr0 == MB_BCAST_ADDR && bcast_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    append  = 1'b0;
    ovf_set = 1'b0;
    gap_set = 1'b0;
    accept  = 1'b0;
    inc_crc = 1'b0;
    inc_gap = 1'b0;
    inc_ovf = 1'b0;
    frm_v   = (state == HOLD);
    busy    = (state == RECV) || (state == CHECK);
    case (state)
      SYNC: begin
        if (silence_done) state_n = IDLE;
      end
      IDLE: begin
        if (rxv) begin
          start   = 1'b1;
          state_n = RECV;
        end
      end
      RECV: begin
        if (rxv) begin
          gap_set = (gap > GAP_T15);
          if (len == LW'(MAX_LEN)) ovf_set = 1'b1;
          else                     append  = 1'b1;
        end else if (silence_done) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (ovf)                                   inc_ovf = 1'b1;
        else if (gap_bad)                          inc_gap = 1'b1;
        else if (len < LW'(4) || crc != 16'h0000)  inc_crc = 1'b1;
        else if (addr_ok)                          accept  = 1'b1;
        if (accept) begin
          state_n = HOLD;
        end else if (rxv) begin
          // a byte exactly t3.5 after the dropped frame opens the next one
          start   = 1'b1;
          state_n = RECV;
        end else begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (frm_ack) state_n = (hold_rx || rxv) ? SYNC : IDLE;
      end
      default: state_n = SYNC;
    endcase
  end

  assign wr_en = start || append;
  assign wr_a  = start ? '0 : len[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      gap       <= '0;
      len       <= '0;
      crc       <= MB_CRC_INIT;
      addr0     <= '0;
      ovf       <= 1'b0;
      gap_bad   <= 1'b0;
      hold_rx   <= 1'b0;
      frm_len   <= '0;
      frm_bcast <= 1'b0;
      cnt_crc   <= '0;
      cnt_gap   <= '0;
      cnt_ovf   <= '0;
    end else begin
      gap <= rxv ? '0 : gap_inc;
      if (start) begin
        len     <= LW'(1);
        crc     <= mb_crc_byte(MB_CRC_INIT, rxd);
        addr0   <= rxd;
        ovf     <= 1'b0;
        gap_bad <= 1'b0;
      end
      if (append) begin
        len <= len + LW'(1);
        crc <= mb_crc_byte(crc, rxd);
      end
      if (ovf_set) ovf     <= 1'b1;
      if (gap_set) gap_bad <= 1'b1;
      if (accept) begin
        frm_len   <= len - LW'(2);
        frm_bcast <= (addr0 == MB_BCAST_ADDR);
        hold_rx   <= rxv;
      end else if (state == HOLD && rxv) begin
        hold_rx <= 1'b1;
      end
      if (inc_crc && cnt_crc != '1) cnt_crc <= cnt_crc + 16'd1;
      if (inc_gap && cnt_gap != '1) cnt_gap <= cnt_gap + 16'd1;
      if (inc_ovf && cnt_ovf != '1) cnt_ovf <= cnt_ovf + 16'd1;
    end
  end

  modbus_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .wa   (wr_a),
    .wd   (rxd),
    .ra   (rd_a),
    .rd_q (rd_q)
  );

endmodule

// File: tb/tb_modbus_rtu_framer.sv
module tb_modbus_rtu_framer;

  localparam int MAX_LEN = 8;
  localparam int T15     = 16;
  localparam int T35     = 40;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] len;
    logic        bcast;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rxv, bcast_en, frm_ack, frm_v, frm_bcast, busy;
  logic [7:0] rxd, slave_addr, rd_q;
  logic [3:0] frm_len;
  logic [2:0] rd_a;
  logic [15:0] cnt_crc, cnt_gap, cnt_ovf;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   m_crc = 0, m_gap = 0, m_ovf = 0;
  int   pushed = 0, mon_done = 0;
  int   ack_delay = 2;
  int   last_cyc = 0;
  exp_t sbq[$];

  modbus_rtu_framer #(
    .MAX_LEN    (MAX_LEN),
    .T15_CYCLES (T15),
    .T35_CYCLES (T35)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxv        (rxv),
    .rxd        (rxd),
    .slave_addr (slave_addr),
    .bcast_en   (bcast_en),
    .frm_v      (frm_v),
    .frm_len    (frm_len),
    .frm_bcast  (frm_bcast),
    .frm_ack    (frm_ack),
    .rd_a       (rd_a),
    .rd_q       (rd_q),
    .busy       (busy),
    .cnt_crc    (cnt_crc),
    .cnt_gap    (cnt_gap),
    .cnt_ovf    (cnt_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference CRC: Modbus CRC-16 of the first n bytes.
  function automatic logic [15:0] ref_crc(input bq_t d, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxv = 1'b1;
    rxd = b;
    last_cyc = cyc;
    @(negedge clk);
    rxv = 1'b0;
  endtask

  task automatic make_frame(input logic [7:0] addr, input int plen, output bq_t d);
    logic [15:0] c;
    d = {};
    d.push_back(addr);
    for (int i = 1; i < plen; i++) d.push_back(8'($urandom_range(0, 255)));
    c = ref_crc(d, plen);
    d.push_back(c[7:0]);
    d.push_back(c[15:8]);
  endtask

  task automatic wait_frames();
    int budget = 400;
    while (mon_done < pushed && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("frames_seen", mon_done, pushed);
  endtask

  task automatic settle();
    idle(T35 + 3);
    wait_frames();
    check("cnt_crc", cnt_crc, m_crc);
    check("cnt_gap", cnt_gap, m_gap);
    check("cnt_ovf", cnt_ovf, m_ovf);
    check("busy_after", busy, 0);
  endtask

  // Sends a frame; sp_fix>0 gives fixed spacing, else random 1..12 cycles.
  // Byte gap_idx is preceded by gap_idle silent cycles. If model is set,
  // the expected outcome is derived from the frame rules.
  task automatic run_frame(input bq_t d, input int sp_fix, input int gap_idx,
                           input int gap_idle, input bit model, input bit do_settle);
    int   n = d.size();
    int   max_idle = 0;
    int   sp;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        if (i == gap_idx)  sp = gap_idle + 1;
        else if (sp_fix > 0) sp = sp_fix;
        else               sp = $urandom_range(1, 12);
        if (sp - 1 > max_idle) max_idle = sp - 1;
        idle(sp - 1);
      end
      send_byte(d[i]);
    end
    if (model) begin
      if (n > MAX_LEN) m_ovf++;
      else if (max_idle > T15) m_gap++;
      else if (n < 4 || ref_crc(d, n - 2) != {d[n-1], d[n-2]}) m_crc++;
      else if (d[0] == slave_addr || (d[0] == 8'h00 && bcast_en)) begin
        e.data = '0;
        for (int i = 0; i < n - 2; i++) e.data[i*8 +: 8] = d[i];
        e.len   = n - 2;
        e.bcast = (d[0] == 8'h00);
        e.cyc   = last_cyc + T35 + 2;
        sbq.push_back(e);
        pushed++;
      end
    end
    if (do_settle) settle();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a frame.
  initial begin
    exp_t e;
    frm_ack = 1'b0;
    rd_a    = '0;
    forever begin
      @(negedge clk);
      if (frm_v === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got frm_v=1 len=%0d at cycle %0d, expected none", frm_len, cyc);
        end else begin
          e = sbq.pop_front();
          check("frm_v_cycle", cyc, e.cyc);
          check("frm_len", 32'(frm_len), e.len);
          check("frm_bcast", frm_bcast, e.bcast);
          for (int i = 0; i < int'(e.len); i++) begin
            rd_a = 3'(i);
            @(negedge clk);
            check($sformatf("rd_q[%0d]", i), rd_q, e.data[i*8 +: 8]);
          end
        end
        repeat (ack_delay) @(negedge clk);
        frm_ack = 1'b1;
        @(negedge clk);
        frm_ack = 1'b0;
        check("frm_v_after_ack", frm_v, 0);
        mon_done++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d, g;
    int  kind, plen, gidx, gidle, idx;
    logic [7:0] addr;

    rst = 1'b1; rxv = 1'b0; rxd = '0; slave_addr = 8'h01; bcast_en = 1'b0;
    idle(3);
    check("rst_frm_v", frm_v, 0);
    check("rst_frm_len", frm_len, 0);
    check("rst_frm_bcast", frm_bcast, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_q", rd_q, 0);
    check("rst_cnt_crc", cnt_crc, 0);
    check("rst_cnt_gap", cnt_gap, 0);
    check("rst_cnt_ovf", cnt_ovf, 0);
    rst = 1'b0;
    idle(T35 + 5);

    g = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    run_frame(g, 10, -1, 0, 1, 1);

    d = g; d[7] = 8'h0B;
    run_frame(d, 10, -1, 0, 1, 0);
    idle(T35);
    run_frame(g, 10, -1, 0, 1, 1);

    run_frame(g, 10, 4, 20, 1, 1);

    slave_addr = 8'h02;
    run_frame(g, 10, -1, 0, 1, 1);
    slave_addr = 8'h01;

    make_frame(8'h00, 5, d);
    bcast_en = 1'b1;
    run_frame(d, 0, -1, 0, 1, 1);
    bcast_en = 1'b0;
    run_frame(d, 0, -1, 0, 1, 1);

    make_frame(8'h01, 8, d);
    run_frame(d, 0, -1, 0, 1, 1);

    // Bytes during HOLD force resync: a frame sent straight after the ack
    // is discarded, the next one after t3.5 silence is accepted.
    ack_delay = 30;
    run_frame(g, 0, -1, 0, 1, 0);
    idle(60);
    send_byte(8'h55);
    idle(4);
    send_byte(8'h66);
    wait_frames();
    ack_delay = 2;
    run_frame(g, 0, -1, 0, 0, 1);
    run_frame(g, 0, -1, 0, 1, 1);

    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 6);
      bcast_en = 1'($urandom_range(0, 1));
      gidx = -1; gidle = 0;
      plen = $urandom_range(2, 6);
      case (kind)
        0, 1: make_frame(8'h01, plen, d);
        2: make_frame(8'h00, plen, d);
        3: begin
          addr = 8'($urandom_range(2, 255));
          make_frame(addr, plen, d);
        end
        4: begin
          make_frame(8'h01, plen, d);
          idx = $urandom_range(0, d.size() - 1);
          d[idx] = d[idx] ^ 8'(1 << $urandom_range(0, 7));
        end
        5: begin
          make_frame(8'h01, plen, d);
          gidx = $urandom_range(1, d.size() - 1);
          gidle = $urandom_range(20, 30);
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            d = {};
            repeat ($urandom_range(1, 3)) d.push_back(8'($urandom_range(0, 255)));
          end else begin
            make_frame(8'h01, $urandom_range(7, 8), d);
          end
        end
      endcase
      run_frame(d, 0, gidx, gidle, 1, 1);
    end

    bcast_en = 1'b0;
    send_byte(8'h01); idle(3); send_byte(8'h03); idle(3); send_byte(8'h00);
    idle(2);
    check("busy_mid_frame", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_crc = 0; m_gap = 0; m_ovf = 0;
    check("midrst_frm_v", frm_v, 0);
    check("midrst_frm_len", frm_len, 0);
    check("midrst_frm_bcast", frm_bcast, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt_crc", cnt_crc, 0);
    check("midrst_cnt_gap", cnt_gap, 0);
    check("midrst_cnt_ovf", cnt_ovf, 0);
    idle(T35 + 5);
    run_frame(g, 0, -1, 0, 1, 1);

    idle(5);
    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
